qpix_cfg_sequencer: RTL

//  Sequences the QPix ASIC 32-bit configuration write from the reg_rw control bits.

---
 rtl/qpix_cfg_pkg.sv | 32 +++
 rtl/qpix_phase_timer.sv | 29 ++
 rtl/qpix_cfg_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/qpix_cfg_pkg.sv
// Shared definitions for the QPix configuration-write sequencer.
// Holds the FSM state encoding, the default word, and build-time timing values.
// SIM values shorten the sclk half-period and the loadData pulse for simulation.
package qpix_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SHIFT_LO = 3'd1,
    ST_SHIFT_HI = 3'd2,
    ST_GAP      = 3'd3,
    ST_LOAD     = 3'd4
  } state_t;

  localparam int unsigned       CFG_WORD_W   = 32;
  localparam logic [31:0]       CFG_DEF_DATA = 32'h0000_0000;

  // 50 MHz system clock: 25 cycles per sclk half-period, 5000 cycles = 100 us
  localparam int unsigned CLK_DIV_SYN  = 25;
  localparam int unsigned LOAD_CYC_SYN = 5000;
  localparam int unsigned CLK_DIV_SIM  = 2;
  localparam int unsigned LOAD_CYC_SIM = 8;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Counter width able to hold n-1; never narrower than one bit
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/qpix_phase_timer.sv
// Loadable down-counter with a terminal-count strobe.
// tc_o is high while the count sits at zero; the count holds at zero (no wrap).
// Loading value V gives V+1 cycles from the load edge to the edge that sees tc_o.
module qpix_phase_timer #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;

  // Reload on request, otherwise count down and park at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/qpix_cfg_sequencer.sv
// Sequences one QPix configuration write: latch word, shift it MSB-first on a
// gated sclk, short gap, then a fixed-length loadData pulse. One phase timer
// times both the sclk half-periods and the loadData duration.
module qpix_cfg_sequencer
  import qpix_cfg_pkg::*;
#(
  parameter int unsigned       WORD_W   = CFG_WORD_W,
  parameter int unsigned       CLK_DIV  = CLK_DIV_SYN,
  parameter int unsigned       LOAD_CYC = LOAD_CYC_SYN,
  parameter logic [WORD_W-1:0] DEF_DATA = CFG_DEF_DATA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              load_only,
  input  logic              sel_def,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic [4:0]        asic_sel,
  output logic [4:0]        sel_out,
  output logic              sclk,
  output logic              sdata,
  output logic              load_data,
  output logic              busy,
  output logic              done
);

  localparam int unsigned      CNT_W       = cnt_w(max2(CLK_DIV, LOAD_CYC));
  localparam int unsigned      BIT_W       = cnt_w(WORD_W);
  localparam logic [CNT_W-1:0] DIV_RELOAD  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] LOAD_RELOAD = CNT_W'(LOAD_CYC - 1);
  localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(WORD_W - 1);

  state_t            state_q;
  logic [WORD_W-1:0] sr_q;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic              start_d_q;
  logic [4:0]        sel_q;
  logic              sclk_q;
  logic              sdata_q;
  logic              load_q;
  logic              busy_q;
  logic              done_q;

  logic              start_edge;
  logic              tc;
  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;

  assign start_edge = start & ~start_d_q;

  // Reload the timer on every state transition with the next state's length
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = DIV_RELOAD;
    case (state_q)
      ST_IDLE: begin
        tmr_load = start_edge;
        if (load_only) tmr_val = LOAD_RELOAD;
      end
      ST_GAP: begin
        tmr_load = tc;
        tmr_val  = LOAD_RELOAD;
      end
      default: tmr_load = tc;
    endcase
  end

  qpix_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tc)
  );

  // Sequencer FSM with registered sclk/sdata/load_data/busy/done/sel_out.
  // start_d tracks start during reset so a start held through reset is no edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      start_d_q <= start;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      sel_q     <= '0;
      sclk_q    <= 1'b0;
      sdata_q   <= 1'b0;
      load_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      start_d_q <= start;
      case (state_q)
        ST_IDLE: begin
          if (start_edge) begin
            sr_q      <= sel_def ? DEF_DATA : cfg_data;
            sdata_q   <= sel_def ? DEF_DATA[WORD_W-1] : cfg_data[WORD_W-1];
            sel_q     <= asic_sel;
            bit_cnt_q <= '0;
            sclk_q    <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            if (load_only) begin
              state_q <= ST_LOAD;
              load_q  <= 1'b1;
            end else begin
              state_q <= ST_SHIFT_LO;
            end
          end
        end
        ST_SHIFT_LO: begin
          if (tc) begin
            sclk_q  <= 1'b1;
            state_q <= ST_SHIFT_HI;
          end
        end
        ST_SHIFT_HI: begin
          if (tc) begin
            sclk_q <= 1'b0;
            if (bit_cnt_q == LAST_BIT) begin
              sdata_q <= 1'b0;
              state_q <= ST_GAP;
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
              // Rotate: next bit comes out of position WORD_W-2
              sr_q      <= {sr_q[WORD_W-2:0], sr_q[WORD_W-1]};
              sdata_q   <= sr_q[WORD_W-2];
              state_q   <= ST_SHIFT_LO;
            end
          end
        end
        ST_GAP: begin
          if (tc) begin
            load_q  <= 1'b1;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (tc) begin
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sel_out   = sel_q;
  assign sclk      = sclk_q;
  assign sdata     = sdata_q;
  assign load_data = load_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
